// File: rtl/traffic_demand_counter.sv
// traffic_demand_counter: debounced lane/pedestrian demand counts, emergency flags
// and light-legality monitor feeding the intersection light controller.
module traffic_demand_counter #(
   parameter int DEB_CYCLES   = 4,
   parameter int SERVE_CYCLES = 2,
   parameter int EMG_CLEAR    = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       main_det,
   input  logic       left_det,
   input  logic       sec_det,
   input  logic       p_btn,
   input  logic       m_emg_req,
   input  logic       s_emg_req,
   input  logic [3:0] m_LRYG,
   input  logic [2:0] s_RYG,
   input  logic       ped,
   output logic [2:0] main_num,
   output logic [2:0] left_num,
   output logic [2:0] sec_num,
   output logic [2:0] p_num,
   output logic       m_emergency,
   output logic       s_emergency,
   output logic       light_err
);
   localparam logic [3:0] DEB_M1 = 4'(DEB_CYCLES - 1);
   localparam logic [3:0] SRV_M1 = 4'(SERVE_CYCLES - 1);
   localparam logic [4:0] EMG_M1 = 5'(EMG_CLEAR - 1);
   logic [3:0] raw, arr;
   logic [2:0] srv;
   logic [2:0] cnt [3];
   logic [1:0] esrv, ereq, eflag;
   logic       bad, ped_srv, ped_q;
   assign raw = {p_btn, sec_det, left_det, main_det};
   assign bad = (m_LRYG == 4'b1111) || ((m_LRYG[0] || m_LRYG[3]) && s_RYG[0]) ||
                (ped && !m_LRYG[0] && s_RYG != 3'b100) ||
                (s_RYG[0] && s_RYG[1]) || (s_RYG[0] && s_RYG[2]) || (s_RYG[1] && s_RYG[2]);
   // Illegal lights suppress every service decode so nothing departs on a bad state
   assign srv[0]  = !bad && m_LRYG == 4'b0001 && !ped;
   assign srv[1]  = !bad && m_LRYG[3] && m_LRYG[2] && !m_LRYG[1] && !m_LRYG[0];
   assign srv[2]  = !bad && s_RYG == 3'b001 && m_LRYG[2];
   assign ped_srv = !bad && ped && s_RYG == 3'b100;
   assign esrv    = {srv[2], srv[0]};
   assign ereq    = {s_emg_req, m_emg_req};
   for (genvar i = 0; i < 4; i++) begin : g_deb
      logic       lvl;
      logic [3:0] c;
      assign arr[i] = raw[i] && !lvl && c == DEB_M1;
      always_ff @(posedge clk) begin
         if (rst) begin
            lvl <= 1'b0;
            c   <= '0;
         end else if (raw[i] == lvl || c == DEB_M1) begin
            lvl <= raw[i];
            c   <= '0;
         end else begin
            c <= c + 1'b1;
         end
      end
   end
   for (genvar i = 0; i < 3; i++) begin : g_lane
      logic [3:0] t;
      logic [2:0] n;
      logic       dep;
      assign dep    = srv[i] && n != 3'd0 && t == SRV_M1;
      assign cnt[i] = n;
      always_ff @(posedge clk) begin
         if (rst) begin
            t <= '0;
            n <= '0;
         end else begin
            t <= (srv[i] && n != 3'd0 && !dep) ? t + 1'b1 : 4'd0;
            if (arr[i] && !dep && n != 3'd7)
               n <= n + 3'd1;
            else if (dep && !arr[i])
               n <= n - 3'd1;
         end
      end
   end
   for (genvar i = 0; i < 2; i++) begin : g_emg
      logic       f;
      logic [4:0] t;
      assign eflag[i] = f;
      always_ff @(posedge clk) begin
         if (rst) begin
            f <= 1'b0;
            t <= '0;
         end else if (ereq[i]) begin
            f <= 1'b1;
            t <= '0;
         end else if (f && esrv[i]) begin
            f <= t != EMG_M1;
            t <= (t == EMG_M1) ? 5'd0 : t + 1'b1;
         end else begin
            t <= '0;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         p_num     <= '0;
         ped_q     <= 1'b0;
         light_err <= 1'b0;
      end else begin
         ped_q     <= ped_srv;
         light_err <= light_err || bad;
         if (ped_srv && !ped_q)
            p_num <= '0;
         else if (!ped_srv && arr[3] && p_num != 3'd7)
            p_num <= p_num + 3'd1;
      end
   end
   assign main_num    = cnt[0];
   assign left_num    = cnt[1];
   assign sec_num     = cnt[2];
   assign m_emergency = eflag[0];
   assign s_emergency = eflag[1];
endmodule
